// File: rtl/tmr_ctrl_pkg.sv
// Shared definitions for the timer controller: FSM encoding, register map, CTRL/STATUS bit positions.
package tmr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PR     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CNT    = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;

    localparam int STAT_MATCH = 0;
    localparam int STAT_CAPV  = 1;

endpackage

// File: rtl/tmr_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a one-cycle rising-edge pulse.
module tmr_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/tmr_ctrl.sv
// Register front-end and run/oneshot FSM for an external timer counter.
// Optional input-capture channel enabled by defining TMR_CAPTURE_EN.
module tmr_ctrl
    import tmr_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   addr,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    input  logic [W-1:0] TMR,
    output logic [W-1:0] PR,
    output logic         EN_TMR,
`ifdef TMR_CAPTURE_EN
    input  logic         cap_in,
`endif
    output logic         irq
);

    state_e         state_q, state_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic [W-1:0]   pr_q, pr_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic           match_q, match_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic           match;
    logic           capv;
    logic [W-1:0]   cnt_rd;

`ifdef TMR_CAPTURE_EN
    logic           cap_pulse;
    logic [W-1:0]   cap_q, cap_d;
    logic           capv_q, capv_d;

    tmr_edge_det u_cap_det (
        .clk   (clk),
        .rst   (rst),
        .d     (cap_in),
        .pulse (cap_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            capv_q <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            capv_q <= capv_d;
        end
    end

    always_comb begin
        cap_d  = cap_q;
        capv_d = capv_q;
        if (wr_en && addr == A_STATUS && wdata[STAT_CAPV])
            capv_d = 1'b0;
        if (cap_pulse && state_q == ST_RUN) begin
            cap_d  = TMR;
            capv_d = 1'b1;
        end
    end

    assign capv   = capv_q;
    assign cnt_rd = cap_q;
`else
    assign capv   = 1'b0;
    assign cnt_rd = TMR;
`endif

    assign match = (state_q == ST_RUN) && (TMR >= pr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            pr_q     <= '0;
            shadow_q <= '0;
            match_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            pr_q     <= pr_d;
            shadow_q <= shadow_d;
            match_q  <= match_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        pr_d     = pr_q;
        shadow_d = shadow_q;
        match_d  = match_q;
        rdata_d  = rdata_q;

        // shadow always tracks the last PR write, so reloading it on every match is harmless
        if (match) begin
            pr_d = shadow_q;
            if (ctrl_q[CTRL_ONESHOT]) begin
                state_d         = ST_DONE;
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        if (wr_en) begin
            case (addr)
                A_CTRL: begin
                    ctrl_d  = wdata[2:0];
                    state_d = wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
                end
                A_PR: begin
                    shadow_d = wdata;
                    if (state_q != ST_RUN) pr_d = wdata;
                end
                A_STATUS: begin
                    if (wdata[STAT_MATCH]) match_d = 1'b0;
                end
                default: ;
            endcase
        end

        // a match on the same edge as a W1C must win
        if (match) match_d = 1'b1;

        if (rd_en) begin
            case (addr)
                A_CTRL:   rdata_d = W'(ctrl_q);
                A_PR:     rdata_d = pr_q;
                A_STATUS: rdata_d = W'({capv, match_q});
                default:  rdata_d = cnt_rd;
            endcase
        end
    end

    assign rdata  = rdata_q;
    assign PR     = pr_q;
    assign EN_TMR = (state_q == ST_RUN);
    assign irq    = ctrl_q[CTRL_IE] & (match_q | capv);

endmodule

// File: tb/tb_tmr_ctrl.sv
// Directed bench for tmr_ctrl with a behavioural timer counter and a read-data scoreboard.
module tb_tmr_ctrl;
    localparam int W = 16;

    typedef struct {
        string        nm;
        logic [31:0]  val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   addr = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic [W-1:0] tmr_cnt;
    logic [W-1:0] PR;
    logic         EN_TMR;
    logic         irq;
`ifdef TMR_CAPTURE_EN
    logic         cap_in = 1'b0;
`endif

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t1, t2;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // timer counter: holds 0 when disabled, counts 0..PR then wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 tmr_cnt <= '0;
        else if (!EN_TMR)        tmr_cnt <= '0;
        else if (tmr_cnt >= PR)  tmr_cnt <= '0;
        else                     tmr_cnt <= tmr_cnt + 1'b1;
    end

    tmr_ctrl #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wdata  (wdata),
        .rdata  (rdata),
        .TMR    (tmr_cnt),
        .PR     (PR),
        .EN_TMR (EN_TMR),
`ifdef TMR_CAPTURE_EN
        .cap_in (cap_in),
`endif
        .irq    (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        addr = a; rd_en = 1'b1;
        sb.push_back('{nm, exp});
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_cnt(input int v, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (tmr_cnt == v[W-1:0]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin n_chk++; $display("FAIL %s: timeout waiting for count %0d", nm, v); end
    endtask

    task automatic wait_irq(output int c, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (irq) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        c = cyc;
        if (!ok) begin n_chk++; $display("FAIL %s: timeout waiting for irq", nm); end
    endtask

    // monitor: every read strobe produces rdata one edge later
    initial begin
        forever begin
            @(posedge clk);
            if (rd_en && !rst) begin
                #1;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL rd_unexpected: got %0d expected no read", rdata);
                end else begin
                    e = sb.pop_front();
                    chk(e.nm, 32'(rdata), e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_en_tmr", 32'(EN_TMR), 0);
        chk("rst_irq", 32'(irq), 0);
        rd(2'd0, 0, "rst_ctrl");
        rd(2'd1, 0, "rst_pr");
        rd(2'd2, 0, "rst_status");

        // periodic run, PR=4, IE
        wr(2'd1, 4);
        rd(2'd1, 4, "pr_idle_write");
        wr(2'd0, 5);
        chk("run_en_tmr", 32'(EN_TMR), 1);
        wait_irq(t1, "irq_first");
        chk("wrap_cnt0", 32'(tmr_cnt), 0);
        wr(2'd2, 1);
        chk("w1c_irq_low", 32'(irq), 0);
        chk("seq_cnt1", 32'(tmr_cnt), 1);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("seq_cnt", 32'(tmr_cnt), 32'(k));
        end
        wait_irq(t2, "irq_second");
        chk("period_cycles", 32'(t2 - t1), 5);
        rd(2'd2, 1, "status_match");
        rd(2'd3, 1, "read_tmr");
        wr(2'd0, 0);
        chk("stop_en_tmr", 32'(EN_TMR), 0);
        chk("stop_irq", 32'(irq), 0);
        wr(2'd2, 1);
        rd(2'd2, 0, "status_cleared");

        // oneshot, PR=2
        wr(2'd1, 2);
        wr(2'd0, 3);
        chk("os_en_tmr", 32'(EN_TMR), 1);
        repeat (3) @(negedge clk);
        chk("os_done_en_tmr", 32'(EN_TMR), 0);
        rd(2'd0, 2, "os_ctrl");
        rd(2'd2, 1, "os_match");
        wr(2'd2, 1);
        repeat (6) @(negedge clk);
        rd(2'd2, 0, "os_single_match");
        chk("os_cnt_held", 32'(tmr_cnt), 0);

        // shadow PR update in RUN
        wr(2'd0, 0);
        wr(2'd1, 9);
        wr(2'd0, 1);
        repeat (2) @(negedge clk);
        chk("sh_cnt2", 32'(tmr_cnt), 2);
        wr(2'd1, 3);
        rd(2'd1, 9, "sh_pr_held");
        wait_cnt(9, "sh_reach9");
        chk("sh_pr_at9", 32'(PR), 9);
        @(negedge clk);
        chk("sh_wrap", 32'(tmr_cnt), 0);
        chk("sh_pr_new", 32'(PR), 3);
        repeat (3) @(negedge clk);
        chk("sh_cnt3", 32'(tmr_cnt), 3);
        @(negedge clk);
        chk("sh_wrap3", 32'(tmr_cnt), 0);
        rd(2'd2, 1, "sh_match");
        wr(2'd0, 0);
        wr(2'd2, 1);

        // match vs W1C on the same edge, then CTRL EN=0 on a match edge
        wr(2'd1, 3);
        wr(2'd0, 1);
        repeat (3) @(negedge clk);
        wr(2'd2, 1);
        rd(2'd2, 1, "set_wins");
        wr(2'd2, 1);
        rd(2'd2, 0, "w1c_nonmatch");
        chk("pre_stop_cnt3", 32'(tmr_cnt), 3);
        wr(2'd0, 0);
        chk("stop_on_match_en", 32'(EN_TMR), 0);
        rd(2'd2, 1, "stop_on_match_status");
        wr(2'd2, 1);

        // PR=0: match every cycle
        wr(2'd1, 0);
        wr(2'd0, 1);
        @(negedge clk);
        chk("pr0_cnt", 32'(tmr_cnt), 0);
        wr(2'd2, 1);
        rd(2'd2, 1, "pr0_match");
        wr(2'd0, 0);
        wr(2'd2, 1);
        rd(2'd2, 0, "pr0_cleared");

        // async reset mid-run with a pending shadow
        wr(2'd1, 9);
        wr(2'd0, 5);
        wr(2'd1, 3);
        rd(2'd1, 9, "rst_pre_pr");
        wait_cnt(6, "rst_reach6");
        #2 rst = 1'b1;
        #1;
        chk("arst_en_tmr", 32'(EN_TMR), 0);
        chk("arst_pr", 32'(PR), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_rdata", 32'(rdata), 0);
        @(negedge clk);
        rst = 1'b0;
        wr(2'd0, 1);
        repeat (3) @(negedge clk);
        rd(2'd1, 0, "arst_shadow_dropped");
        rd(2'd0, 1, "arst_ctrl");
        wr(2'd0, 0);
        wr(2'd2, 1);

`ifdef TMR_CAPTURE_EN
        wr(2'd1, 20);
        wr(2'd0, 1);
        wait_cnt(7, "cap_reach7");
        cap_in = 1'b1;
        repeat (2) @(negedge clk);
        cap_in = 1'b0;
        repeat (2) @(negedge clk);
        rd(2'd3, 9, "cap_value");
        rd(2'd2, 2, "cap_capv");
        wr(2'd0, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tmr_ctrl.md
TMR_CTRL -- requirements
Module: tmr_ctrl

Interface
REQ-001 Parameter: W, 16, width of the period and count fields and of rdata/wdata.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 addr  input  2  register select: 0 CTRL, 1 PR, 2 STATUS, 3 CNT/CAP.
REQ-005 wr_en  input  1  register write strobe, sampled at the clk edge.
REQ-006 rd_en  input  1  register read strobe, sampled at the clk edge.
REQ-007 wdata  input  W  write data.
REQ-008 rdata  output  W  registered read data.
REQ-009 TMR  input  W  current count from the timer counter.
REQ-010 PR  output  W  active period value driven to the timer counter.
REQ-011 EN_TMR  output  1  counter enable; low holds the counter at 0.
REQ-012 irq  output  1  level interrupt = CTRL.IE AND STATUS.MATCH.

Function
REQ-013 CTRL bit layout SHALL be: bit0 EN, bit1 ONESHOT, bit2 IE; other bits read 0.
REQ-014 FSM states SHALL be IDLE, RUN and DONE; EN_TMR SHALL be 1 only in RUN.
REQ-015 IDLE->RUN and DONE->RUN SHALL occur on the edge of a CTRL write with EN=1.
REQ-016 RUN->IDLE and DONE->IDLE SHALL occur on the edge of a CTRL write with EN=0.
REQ-017 Match SHALL be defined as state RUN AND TMR >= PR (unsigned), evaluated each cycle.
REQ-018 On match, STATUS.MATCH SHALL set on the same edge, so the period is PR+1 cycles.
REQ-019 On match with ONESHOT=1, FSM SHALL go RUN->DONE and clear CTRL.EN on the same edge.
REQ-020 A PR write in IDLE or DONE SHALL update the PR output on the write edge.
REQ-021 A PR write in RUN SHALL load a shadow register; PR output SHALL take the shadow value on the next match edge.
REQ-022 A STATUS write SHALL clear each bit written as 1 (write-1-to-clear).
REQ-023 A match and a W1C of MATCH on the same edge SHALL leave MATCH = 1 (set wins).
REQ-024 A CTRL write with EN=0 and a match on the same edge SHALL give IDLE and MATCH = 1.
REQ-025 rdata SHALL present the addressed register one cycle after rd_en and hold it until the next rd_en.
REQ-026 Reading addr 3 SHALL return TMR.
REQ-027 PR = 0 in RUN SHALL produce a match on every cycle.

Reset
REQ-028 rst SHALL force: state IDLE, CTRL = 0, PR = 0, shadow = 0, STATUS = 0, rdata = 0, EN_TMR = 0, irq = 0.
REQ-029 rst asserted mid-RUN SHALL take effect without a clock edge, and any pending shadow PR SHALL be discarded.

Configuration
REQ-030 With TMR_CAPTURE_EN defined, the block SHALL add input cap_in (1 bit), synchronised through two flops.
REQ-031 With TMR_CAPTURE_EN defined, each rising edge of the synchronised cap_in in RUN SHALL latch TMR into CAP and set STATUS bit1 CAPV.
REQ-032 With TMR_CAPTURE_EN defined, addr 3 SHALL read CAP, and irq SHALL also assert for IE AND CAPV.
REQ-033 With TMR_CAPTURE_EN undefined, cap_in, CAP and CAPV SHALL be absent, and STATUS bit1 SHALL read 0.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the register address constants, and the CTRL/STATUS bit indices.
REQ-035 Sub-module tmr_edge_det (2-flop synchroniser plus rising-edge pulse) SHALL be instantiated only under TMR_CAPTURE_EN.
REQ-036 The timer counter SHALL stay a separate instance connected through TMR, PR and EN_TMR.

Verification
REQ-037 Write PR=4, then CTRL=0x5 (EN, IE) -> EN_TMR=1; MATCH and irq assert every 5 cycles; count sequence 0..4.
REQ-038 Write CTRL=0x3 (EN, ONESHOT) with PR=2 -> exactly one match; state DONE; EN_TMR=0; CTRL reads 0x2.
REQ-039 In RUN with PR=9, write PR=3 at count 2 -> current period completes at 9, next period ends at 3.
REQ-040 Force match and W1C STATUS=0x1 on the same edge -> MATCH reads 1; a W1C on a later non-match cycle -> 0.
REQ-041 Assert rst at count 6 in RUN -> EN_TMR, PR, irq and rdata drop to 0 immediately; state IDLE.
REQ-042 With TMR_CAPTURE_EN, pulse cap_in at count 7, PR=20 -> CAP reads 9 (7 + 2 sync cycles); CAPV = 1.
